// File: rtl/inst_fetch_pkg.sv
// rtl/inst_fetch_pkg.sv - shared core constants and fetch FSM state type
package inst_fetch_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;
    localparam logic DATA_0  = 1'b0;
    localparam logic DATA_1  = 1'b1;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2,
        ST_ERR  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/inst_fetch_if.sv
// rtl/inst_fetch_if.sv - instruction memory request/response bundle
interface inst_fetch_if;
    import inst_fetch_pkg::*;

    logic            imem_req_o;
    logic [XLEN-1:0] imem_addr_o;
    logic            imem_rvalid_i;
    logic [XLEN-1:0] imem_rdata_i;

    modport master (
        output imem_req_o,
        output imem_addr_o,
        input  imem_rvalid_i,
        input  imem_rdata_i
    );

    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_rvalid_i,
        output imem_rdata_i
    );

endinterface

// File: rtl/inst_fetch_pc.sv
// rtl/inst_fetch_pc.sv - program counter, +4 adder, target mux and alignment check
module inst_fetch_pc
    import inst_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            pc_load_i,
    input  logic            pcmux_sel_i,
    input  logic [XLEN-1:0] alu_data_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_four_o,
    output logic            target_ok_o
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] target;

    assign pc_o      = pc_q;
    assign pc_four_o = pc_q + XLEN'(4);

    // JALR semantics: jump targets always have bit 0 cleared before the alignment test
    always_comb begin
        target = pc_four_o;
        case (pcmux_sel_i)
            DATA_0:  target = pc_four_o;
            DATA_1:  target = alu_data_i & ~XLEN'(1);
            default: target = pc_four_o;
        endcase
    end

    assign target_ok_o = (target[1:0] == 2'b00);

    always_comb begin
        pc_d = pc_q;
        if (pc_load_i) begin
            pc_d = target;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch unit: fetch FSM, instruction register, instret counter
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC      = 32'h0000_0000,
    parameter logic [XLEN-1:0] RESET_INSTRET = 32'h0000_0000
) (
    input  logic            clk_i,
    input  logic            rst_i,
    inst_fetch_if.master    imem,
    input  logic            pc_en_i,
    input  logic            pcmux_sel_i,
    input  logic [XLEN-1:0] alu_data_i,
    output logic [XLEN-1:0] inst_o,
    output logic            inst_valid_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_four_o,
    output logic            misalign_o,
    output logic [XLEN-1:0] instret_o
);

    fetch_state_e    state_q;
    fetch_state_e    state_d;
    logic [XLEN-1:0] inst_q;
    logic [XLEN-1:0] inst_d;
    logic [XLEN-1:0] instret_q;
    logic [XLEN-1:0] instret_d;
    logic            inst_valid_q;
    logic            inst_valid_d;
    logic            misalign_q;
    logic            misalign_d;
    logic            commit;
    logic            target_ok;
    logic            pc_load;

    inst_fetch_pc #(
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .pc_load_i   (pc_load),
        .pcmux_sel_i (pcmux_sel_i),
        .alu_data_i  (alu_data_i),
        .pc_o        (pc_o),
        .pc_four_o   (pc_four_o),
        .target_ok_o (target_ok)
    );

    assign commit  = (state_q == ST_HOLD) && (pc_en_i == ENABLE);
    assign pc_load = commit && target_ok;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_REQ;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_REQ:  state_d = ST_WAIT;
            ST_WAIT: if (imem.imem_rvalid_i) state_d = ST_HOLD;
            ST_HOLD: if (commit) state_d = target_ok ? ST_REQ : ST_ERR;
            ST_ERR:  state_d = ST_ERR;
            default: state_d = ST_ERR;
        endcase
    end

    // Reset state is ST_REQ, so the request is masked while rst_i is held
    always_comb begin
        imem.imem_req_o = DISABLE;
        if ((state_q == ST_REQ) && !rst_i) begin
            imem.imem_req_o = ENABLE;
        end
    end

    assign imem.imem_addr_o = pc_o;

    always_comb begin
        inst_d       = inst_q;
        inst_valid_d = inst_valid_q;
        misalign_d   = misalign_q;
        instret_d    = instret_q;
        if ((state_q == ST_WAIT) && imem.imem_rvalid_i) begin
            inst_d       = imem.imem_rdata_i;
            inst_valid_d = 1'b1;
        end
        if (commit) begin
            inst_valid_d = 1'b0;
            if (target_ok) begin
                instret_d = instret_q + XLEN'(1);
            end else begin
                misalign_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            inst_q       <= NOP;
            inst_valid_q <= 1'b0;
            misalign_q   <= 1'b0;
            instret_q    <= RESET_INSTRET;
        end else begin
            inst_q       <= inst_d;
            inst_valid_q <= inst_valid_d;
            misalign_q   <= misalign_d;
            instret_q    <= instret_d;
        end
    end

    assign inst_o       = inst_q;
    assign inst_valid_o = inst_valid_q;
    assign misalign_o   = misalign_q;
    assign instret_o    = instret_q;

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - self-checking bench for inst_fetch
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pc_en = 1'b0;
    logic        sel = 1'b0;
    logic [31:0] alu = 32'h0;
    logic [31:0] inst, pc, pc_four, instret;
    logic        inst_valid, misalign;

    logic        pc_en_b = 1'b0;
    logic [31:0] inst_b, pc_b, pc_four_b, instret_b;
    logic        valid_b, mis_b;

    int          checks = 0;
    int          errors = 0;
    int          lat = 1;
    int          pend = 0;
    logic        spur = 1'b0;
    logic [31:0] paddr = 32'h0;
    logic        b_pend = 1'b0;

    int          m_phase;
    logic [31:0] m_pc, m_inst, m_instret;
    logic        m_valid, m_mis;

    inst_fetch_if bus_a ();
    inst_fetch_if bus_b ();

    always #5 clk = ~clk;

    inst_fetch dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .imem         (bus_a),
        .pc_en_i      (pc_en),
        .pcmux_sel_i  (sel),
        .alu_data_i   (alu),
        .inst_o       (inst),
        .inst_valid_o (inst_valid),
        .pc_o         (pc),
        .pc_four_o    (pc_four),
        .misalign_o   (misalign),
        .instret_o    (instret)
    );

    inst_fetch #(
        .RESET_PC      (32'hFFFF_FFFC),
        .RESET_INSTRET (32'hFFFF_FFFF)
    ) dut_b (
        .clk_i        (clk),
        .rst_i        (rst),
        .imem         (bus_b),
        .pc_en_i      (pc_en_b),
        .pcmux_sel_i  (1'b0),
        .alu_data_i   (32'h0),
        .inst_o       (inst_b),
        .inst_valid_o (valid_b),
        .pc_o         (pc_b),
        .pc_four_o    (pc_four_b),
        .misalign_o   (mis_b),
        .instret_o    (instret_b)
    );

    function automatic logic [31:0] word(input logic [31:0] a);
        return 32'h0050_0093 ^ (a << 8);
    endfunction

    function automatic logic [31:0] next_pc(input logic s, input logic [31:0] a, input logic [31:0] p);
        if (s) return a & 32'hFFFF_FFFE;
        return p + 32'd4;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic commit_pc(input logic s, input logic [31:0] a);
        pc_en = 1'b1;
        sel   = s;
        alu   = a;
        cyc();
        pc_en = 1'b0;
        sel   = 1'b0;
        alu   = 32'h0;
    endtask

    task automatic wait_valid(input string nm);
        int n;
        n = 0;
        while (!inst_valid && n < 30) begin
            cyc();
            n++;
        end
        chk1(nm, inst_valid, 1'b1);
    endtask

    task automatic release_rst();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc();
    endtask

    // memory model: answers each request after lat cycles, plus injected spurious pulses
    initial begin
        bus_a.imem_rvalid_i = 1'b0;
        bus_a.imem_rdata_i  = 32'h0;
        bus_b.imem_rvalid_i = 1'b0;
        bus_b.imem_rdata_i  = 32'h0000_0013;
        forever begin
            @(negedge clk);
            bus_a.imem_rvalid_i = 1'b0;
            bus_a.imem_rdata_i  = 32'h0;
            if (rst) begin
                pend = 0;
            end else begin
                if (spur) begin
                    bus_a.imem_rvalid_i = 1'b1;
                    bus_a.imem_rdata_i  = 32'hDEAD_BEEF;
                    spur = 1'b0;
                end
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        bus_a.imem_rvalid_i = 1'b1;
                        bus_a.imem_rdata_i  = word(paddr);
                    end
                end
                if (bus_a.imem_req_o) begin
                    pend  = lat;
                    paddr = bus_a.imem_addr_o;
                end
            end
            bus_b.imem_rvalid_i = b_pend;
            b_pend = bus_b.imem_req_o && !rst;
        end
    end

    // phase: 0 = issue request, 1 = awaiting response, 2 = holding instruction, 3 = dead
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase   <= 0;
            m_pc      <= 32'h0;
            m_inst    <= 32'h0000_0013;
            m_valid   <= 1'b0;
            m_mis     <= 1'b0;
            m_instret <= 32'h0;
        end else begin
            case (m_phase)
                0: m_phase <= 1;
                1: if (bus_a.imem_rvalid_i) begin
                    m_inst  <= bus_a.imem_rdata_i;
                    m_valid <= 1'b1;
                    m_phase <= 2;
                end
                2: if (pc_en) begin
                    m_valid <= 1'b0;
                    if (next_pc(sel, alu, m_pc) % 4 == 0) begin
                        m_pc      <= next_pc(sel, alu, m_pc);
                        m_instret <= m_instret + 32'd1;
                        m_phase   <= 0;
                    end else begin
                        m_mis   <= 1'b1;
                        m_phase <= 3;
                    end
                end
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        chk("cmp_inst", inst, m_inst);
        chk1("cmp_inst_valid", inst_valid, m_valid);
        chk("cmp_pc", pc, m_pc);
        chk("cmp_pc_four", pc_four, m_pc + 32'd4);
        chk("cmp_addr", bus_a.imem_addr_o, m_pc);
        chk1("cmp_req", bus_a.imem_req_o, (m_phase == 0) && !rst);
        chk1("cmp_misalign", misalign, m_mis);
        chk("cmp_instret", instret, m_instret);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) cyc();
        chk1("rst_req", bus_a.imem_req_o, 1'b0);
        chk("rst_inst", inst, 32'h0000_0013);
        chk1("rst_valid", inst_valid, 1'b0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_instret", instret, 32'h0);
        chk1("rst_misalign", misalign, 1'b0);

        release_rst();
        chk1("c1_req", bus_a.imem_req_o, 1'b1);
        chk("c1_addr", bus_a.imem_addr_o, 32'h0);
        cyc();
        chk1("c2_valid", inst_valid, 1'b0);
        cyc();
        chk("c3_inst", inst, 32'h0050_0093);
        chk1("c3_valid", inst_valid, 1'b1);
        chk("c3_pc_four", pc_four, 32'h4);
        chk("b_pc_reset", pc_b, 32'hFFFF_FFFC);
        chk("b_pc_four_wrap", pc_four_b, 32'h0);
        chk1("b_valid", valid_b, 1'b1);
        chk("b_instret_reset", instret_b, 32'hFFFF_FFFF);

        pc_en_b = 1'b1;
        commit_pc(1'b0, 32'h0);
        pc_en_b = 1'b0;
        chk("seq_pc", pc, 32'h4);
        chk1("seq_req", bus_a.imem_req_o, 1'b1);
        chk("seq_addr", bus_a.imem_addr_o, 32'h4);
        chk("seq_instret", instret, 32'h1);
        chk1("seq_valid_low", inst_valid, 1'b0);
        chk("model_pc", m_pc, 32'h4);
        chk("model_instret", m_instret, 32'h1);
        chk("b_pc_wrapped", pc_b, 32'h0);
        chk("b_instret_wrapped", instret_b, 32'h0);
        chk1("b_misalign", mis_b, 1'b0);
        cyc();
        chk1("seq_valid_wait", inst_valid, 1'b0);
        cyc();
        chk1("seq_valid_back", inst_valid, 1'b1);
        chk("seq_inst", inst, word(32'h4));

        commit_pc(1'b1, 32'h0000_0101);
        chk("br_pc", pc, 32'h100);
        chk("br_addr", bus_a.imem_addr_o, 32'h100);
        chk1("br_req", bus_a.imem_req_o, 1'b1);
        chk("br_instret", instret, 32'h2);
        wait_valid("br_valid");
        chk("br_inst", inst, word(32'h100));

        spur = 1'b1;
        repeat (3) cyc();
        chk("spur_inst", inst, word(32'h100));
        chk("spur_pc", pc, 32'h100);
        chk("spur_instret", instret, 32'h2);

        lat = 5;
        commit_pc(1'b0, 32'h0);
        chk("lat_pc", pc, 32'h104);
        cyc();
        commit_pc(1'b1, 32'h200);
        repeat (3) cyc();
        chk1("lat_rvalid", bus_a.imem_rvalid_i, 1'b1);
        chk1("lat_valid_before", inst_valid, 1'b0);
        chk("lat_pc_ignored_en", pc, 32'h104);
        chk("lat_instret", instret, 32'h3);
        cyc();
        chk1("lat_valid_after", inst_valid, 1'b1);
        chk("lat_inst", inst, word(32'h104));

        lat = 1;
        commit_pc(1'b1, 32'hFFFF_FFFD);
        chk("wrap_pc_top", pc, 32'hFFFF_FFFC);
        chk("wrap_pc_four", pc_four, 32'h0);
        wait_valid("wrap_valid");
        commit_pc(1'b0, 32'h0);
        chk("wrap_pc", pc, 32'h0);
        chk("wrap_instret", instret, 32'h5);
        wait_valid("wrap_valid2");

        commit_pc(1'b1, 32'h0000_0102);
        chk1("mis_flag", misalign, 1'b1);
        chk("mis_pc", pc, 32'h0);
        chk("mis_instret", instret, 32'h5);
        chk1("mis_valid", inst_valid, 1'b0);
        chk1("mis_req", bus_a.imem_req_o, 1'b0);
        spur = 1'b1;
        cyc();
        commit_pc(1'b0, 32'h0);
        commit_pc(1'b1, 32'h200);
        repeat (3) cyc();
        chk1("mis_sticky", misalign, 1'b1);
        chk1("mis_no_req", bus_a.imem_req_o, 1'b0);
        chk("mis_pc_hold", pc, 32'h0);
        chk("mis_instret_hold", instret, 32'h5);

        rst = 1'b1;
        cyc();
        release_rst();
        chk1("rr_misalign", misalign, 1'b0);
        cyc();
        cyc();
        chk1("rr_valid", inst_valid, 1'b1);
        lat = 3;
        commit_pc(1'b0, 32'h0);
        cyc();
        chk("rw_pc_before", pc, 32'h4);
        chk("rw_instret_before", instret, 32'h1);
        rst = 1'b1;
        #1;
        chk("rw_pc", pc, 32'h0);
        chk("rw_pc_four", pc_four, 32'h4);
        chk("rw_inst", inst, 32'h0000_0013);
        chk1("rw_valid", inst_valid, 1'b0);
        chk("rw_instret", instret, 32'h0);
        chk1("rw_misalign", misalign, 1'b0);
        chk1("rw_req", bus_a.imem_req_o, 1'b0);
        cyc();
        lat = 1;
        release_rst();
        repeat (4) cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
